// File: rtl/onehot_pkg.sv
// Shared types and helpers for one-hot producers and consumers.
package onehot_pkg;

  // Widest one-hot vector any client may request.
  localparam int unsigned MaxSize = 256;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } state_e;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Binary code to one-hot; callers truncate to their own width.
  function automatic logic [MaxSize-1:0] code_to_onehot(input logic [7:0] code);
    logic [MaxSize-1:0] oh;
    oh = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pend_buf.sv
// One-entry holding register with full flag; write wins over read.
module pend_buf #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_full;

  // Capture on write, release on read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Decodes handshaked binary codes into timed one-hot pulses followed by a zero gap.
module onehot_pulse_decoder
  import onehot_pkg::*;
#(
  parameter int unsigned SIZE = 8,
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1,
  localparam int unsigned W   = clog2(SIZE)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [W-1:0]    i_in,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic [SIZE-1:0] o_out,
  output logic            o_out_valid,
  output logic            o_busy,
  output logic            o_err
);

  localparam int unsigned MaxHoldGap = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW         = clog2(MaxHoldGap + 1);
  localparam logic [CW-1:0] HoldLoad = CW'(HOLD - 1);
  localparam logic [CW-1:0] GapLoad  = CW'((GAP > 0) ? GAP - 1 : 0);

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [W-1:0]    r_cur, w_cur_d;
  logic [SIZE-1:0] r_out, w_out_d;
  logic            r_out_valid;
  logic            r_busy, w_busy_d;
  logic            r_err, w_err_d;

  logic            w_accept;
  logic            w_in_ok;
  logic            w_pend_ok;
  logic            w_pend_wr;
  logic            w_pend_rd;
  logic            w_pend_full;
  logic            w_pend_full_d;
  logic [W-1:0]    w_pend_data;
  logic            w_load;

  assign o_in_ready = !w_pend_full && !i_rst;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_in_ok    = 32'(i_in) < SIZE;
  assign w_pend_ok  = 32'(w_pend_data) < SIZE;

  pend_buf #(
    .W(W)
  ) u_pend_buf (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_wr  (w_pend_wr),
    .i_rd  (w_pend_rd),
    .i_data(i_in),
    .o_data(w_pend_data),
    .o_full(w_pend_full)
  );

  // Next-state: count down HOLD/GAP, then pick up the pending code or a same-edge accept.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_cur_d   = r_cur;
    w_err_d   = 1'b0;
    w_pend_wr = 1'b0;
    w_pend_rd = 1'b0;
    w_load    = 1'b0;

    unique case (r_state)
      StIdle: w_load = 1'b1;
      StHold: begin
        if (r_cnt == '0) begin
          if (GAP > 0) begin
            w_state_d = StGap;
            w_cnt_d   = GapLoad;
            w_pend_wr = w_accept;
          end else begin
            w_load = 1'b1;
          end
        end else begin
          w_cnt_d   = r_cnt - CW'(1);
          w_pend_wr = w_accept;
        end
      end
      StGap: begin
        if (r_cnt == '0) begin
          w_load = 1'b1;
        end else begin
          w_cnt_d   = r_cnt - CW'(1);
          w_pend_wr = w_accept;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Pending code has priority; in_ready keeps a fresh accept from coinciding with it.
    if (w_load) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      if (w_pend_full) begin
        w_pend_rd = 1'b1;
        if (w_pend_ok) begin
          w_cur_d   = w_pend_data;
          w_state_d = StHold;
          w_cnt_d   = HoldLoad;
        end else begin
          w_err_d = 1'b1;
        end
      end else if (w_accept) begin
        if (w_in_ok) begin
          w_cur_d   = i_in;
          w_state_d = StHold;
          w_cnt_d   = HoldLoad;
        end else begin
          w_err_d = 1'b1;
        end
      end
    end

    w_pend_full_d = w_pend_wr || (w_pend_full && !w_pend_rd);
    w_busy_d      = (w_state_d != StIdle) || w_pend_full_d;
    w_out_d       = (w_state_d == StHold) ? SIZE'(code_to_onehot(8'(w_cur_d))) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_cur       <= w_cur_d;
      r_out       <= w_out_d;
      r_out_valid <= (w_state_d == StHold);
      r_busy      <= w_busy_d;
      r_err       <= w_err_d;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench: three decoder configurations, scoreboard of expected pulse codes.
module tb_onehot_pulse_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       rst;
  logic [2:0] a_in, b_in, c_in;
  logic       a_vld, b_vld, c_vld;
  logic       a_rdy, b_rdy, c_rdy;
  logic [7:0] a_out, b_out;
  logic [5:0] c_out;
  logic       a_ov, b_ov, c_ov;
  logic       a_busy, b_busy, c_busy;
  logic       a_err, b_err, c_err;

  // a: SIZE=8 HOLD=4 GAP=1; b: GAP=0; c: SIZE=6 (codes 6,7 out of range)
  onehot_pulse_decoder #(.SIZE(8), .HOLD(4), .GAP(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_in(a_in), .i_in_valid(a_vld), .o_in_ready(a_rdy),
    .o_out(a_out), .o_out_valid(a_ov), .o_busy(a_busy), .o_err(a_err)
  );
  onehot_pulse_decoder #(.SIZE(8), .HOLD(4), .GAP(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_in(b_in), .i_in_valid(b_vld), .o_in_ready(b_rdy),
    .o_out(b_out), .o_out_valid(b_ov), .o_busy(b_busy), .o_err(b_err)
  );
  onehot_pulse_decoder #(.SIZE(6), .HOLD(4), .GAP(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_in(c_in), .i_in_valid(c_vld), .o_in_ready(c_rdy),
    .o_out(c_out), .o_out_valid(c_ov), .o_busy(c_busy), .o_err(c_err)
  );

  int q0[$];
  int q1[$];
  int q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic rdy_of(input int k);
    case (k)
      0: return a_rdy;
      1: return b_rdy;
      default: return c_rdy;
    endcase
  endfunction

  // Pulse monitor: each new non-zero output must match the oldest expected code and last HOLD cycles.
  logic [7:0] prev_out[3];
  int         run_len[3];

  task automatic mon(input int k, input logic [7:0] o, input logic ov);
    logic [7:0] e;
    if (rst) begin
      prev_out[k] = '0;
      run_len[k]  = 0;
    end else begin
      if (o != prev_out[k]) begin
        if (prev_out[k] != 8'd0) chk($sformatf("pulse_len[%0d]", k), run_len[k], 4);
        if (o != 8'd0) begin
          if (qsize(k) == 0) begin
            chk($sformatf("unexpected_pulse[%0d]", k), o, 0);
          end else begin
            e = 8'd1 << qpop(k);
            chk($sformatf("pulse_code[%0d]", k), o, e);
          end
          chk($sformatf("out_valid_hi[%0d]", k), ov, 1);
          run_len[k] = 1;
        end else begin
          chk($sformatf("out_valid_lo[%0d]", k), ov, 0);
        end
      end else if (o != 8'd0) begin
        run_len[k]++;
      end
      prev_out[k] = o;
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_out, a_ov);
    mon(1, b_out, b_ov);
    mon(2, {2'b00, c_out}, c_ov);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a code (valid stays high), wait for acceptance, return one negedge after the accept edge.
  task automatic send(input int k, input int code);
    int guard;
    guard = 0;
    case (k)
      0: begin a_in = 3'(code); a_vld = 1'b1; end
      1: begin b_in = 3'(code); b_vld = 1'b1; end
      default: begin c_in = 3'(code); c_vld = 1'b1; end
    endcase
    while (!rdy_of(k) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("accept_wait[%0d]", k), (guard < 50) ? 32'd1 : 32'd0, 1);
    if (code < ((k == 2) ? 6 : 8)) begin
      case (k)
        0: q0.push_back(code);
        1: q1.push_back(code);
        default: q2.push_back(code);
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    a_in = '0; b_in = '0; c_in = '0;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    cyc(3);
    chk("rst_ready", a_rdy, 0);
    chk("rst_out", a_out, 0);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    cyc(1);
    chk("ready_after_rst", a_rdy, 1);

    // Single accept: in=5
    send(0, 5);
    a_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("single_out_t%0d", i), a_out, 8'h20);
      chk($sformatf("single_ready_t%0d", i), a_rdy, 1);
      if (i < 4) cyc(1);
    end
    cyc(1);
    chk("single_gap_out", a_out, 0);
    chk("single_gap_busy", a_busy, 1);
    cyc(1);
    chk("single_idle_busy", a_busy, 0);
    chk("single_idle_out", a_out, 0);
    cyc(2);

    // Back-to-back: 0 then 7
    send(0, 0);
    send(0, 7);
    a_vld = 1'b0;
    chk("b2b_ready_drop", a_rdy, 0);
    chk("b2b_out_t2", a_out, 8'h01);
    cyc(2);
    chk("b2b_out_t4", a_out, 8'h01);
    cyc(1);
    chk("b2b_gap_t5", a_out, 0);
    cyc(1);
    chk("b2b_out_t6", a_out, 8'h80);
    chk("b2b_ready_t6", a_rdy, 1);
    cyc(3);
    chk("b2b_out_t9", a_out, 8'h80);
    cyc(1);
    chk("b2b_gap_t10", a_out, 0);
    cyc(2);

    // GAP=0 chaining: 2 then 3
    send(1, 2);
    send(1, 3);
    b_vld = 1'b0;
    cyc(2);
    chk("chain_out_t4", b_out, 8'h04);
    cyc(1);
    chk("chain_out_t5", b_out, 8'h08);
    cyc(3);
    chk("chain_out_t8", b_out, 8'h08);
    cyc(1);
    chk("chain_end_t9", b_out, 0);
    chk("chain_busy_t9", b_busy, 0);

    // Out-of-range in IDLE (SIZE=6, code 6)
    send(2, 6);
    c_vld = 1'b0;
    chk("oor_err", c_err, 1);
    chk("oor_out", c_out, 0);
    chk("oor_busy", c_busy, 0);
    cyc(1);
    chk("oor_err_once", c_err, 0);
    chk("oor_ready", c_rdy, 1);

    // Out-of-range code queued behind a valid one: dropped at load with an err pulse
    send(2, 1);
    send(2, 7);
    c_vld = 1'b0;
    chk("oor_pend_out_t2", c_out, 6'h02);
    cyc(3);
    chk("oor_pend_gap_err", c_err, 0);
    chk("oor_pend_gap_busy", c_busy, 1);
    cyc(1);
    chk("oor_pend_err", c_err, 1);
    chk("oor_pend_out", c_out, 0);
    chk("oor_pend_busy", c_busy, 0);
    cyc(1);
    chk("oor_pend_err_once", c_err, 0);

    // Reset during the second HOLD cycle with a pending code
    send(0, 3);
    send(0, 6);
    a_vld = 1'b0;
    chk("midrst_busy_before", a_busy, 1);
    rst = 1'b1;
    q0.delete();
    cyc(1);
    chk("midrst_out", a_out, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_err", a_err, 0);
    rst = 1'b0;
    cyc(8);
    chk("midrst_no_replay", a_out, 0);
    send(0, 4);
    a_vld = 1'b0;
    chk("midrst_new_code", a_out, 8'h10);
    cyc(6);

    // Stall: valid held high, code advances only on accepted edges
    for (int i = 0; i < 8; i++) send(0, i);
    a_vld = 1'b0;
    guard = 0;
    while ((q0.size() != 0 || a_busy) && guard < 200) begin
      cyc(1);
      guard++;
    end
    chk("stall_drain_timeout", (guard < 200) ? 32'd1 : 32'd0, 1);
    cyc(3);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);
    chk("end_busy", a_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
